// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, status flags and multiplier FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_MUL = 3'd7
  } operation_t;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } alu_flags_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, product held until ack.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ack,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  mul_state_t     state, state_nxt;
  logic [PW-1:0]  acc, acc_nxt;
  logic [PW-1:0]  mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [SHW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MUL_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // DONE leaves acc untouched, so a stalled sink cannot disturb the product.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          state_nxt  = MUL_BUSY;
          acc_nxt    = '0;
          mcand_nxt  = {{WIDTH{1'b0}}, a};
          mplier_nxt = b;
          cnt_nxt    = '0;
        end
      end
      MUL_BUSY: begin
        if (mplier[0]) acc_nxt = acc + mcand;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + SHW'(1);
        if (cnt == SHW'(WIDTH - 1)) state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        if (ack) state_nxt = MUL_IDLE;
      end
      default: state_nxt = MUL_IDLE;
    endcase
  end

  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU with valid/ready on both sides; MUL stalls stage 1 while it iterates.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  operation_t       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned WW  = WIDTH + 1;

  operation_t       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_valid;

  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               advance;
  logic [WIDTH-1:0]   res;
  logic [WW-1:0]      wide;
  alu_flags_t         flags;
  logic [SHW-1:0]     shamt;

  assign advance  = s1_valid && ((s1_op != OP_MUL) || mul_done) && (!out_valid || out_ready);
  assign in_ready = !s1_valid || advance;
  assign shamt    = s1_b[SHW-1:0];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (s1_valid && (s1_op == OP_MUL)),
    .ack     (advance && (s1_op == OP_MUL)),
    .a       (s1_a),
    .b       (s1_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_op    <= OP_NOP;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_op    <= op_in;
      s1_a     <= a_in;
      s1_b     <= b_in;
      s1_valid <= 1'b1;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Result and flags; the extra top bit of "wide" carries the carry/shift-out.
  always_comb begin
    res   = '0;
    wide  = '0;
    flags = '0;
    case (s1_op)
      OP_ADD: begin
        wide        = {1'b0, s1_a} + {1'b0, s1_b};
        res         = wide[WIDTH-1:0];
        flags.carry = wide[WIDTH];
        flags.ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        wide        = {1'b0, s1_a} + {1'b0, ~s1_b} + WW'(1);
        res         = wide[WIDTH-1:0];
        flags.carry = wide[WIDTH];
        flags.ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (res[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_XOR: res = s1_a ^ s1_b;
      OP_SHL: begin
        wide        = {1'b0, s1_a} << shamt;
        res         = wide[WIDTH-1:0];
        flags.carry = wide[WIDTH];
      end
      OP_MUL: begin
        res         = mul_product[WIDTH-1:0];
        flags.carry = |mul_product[2*WIDTH-1:WIDTH];
      end
      default: res = '0;
    endcase
    flags.zero = (res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_flags <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      out       <= res;
      out_flags <= flags;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
